// File: rtl/mario_sprite_pkg.sv
// rtl/mario_sprite_pkg.sv - shared sprite constants, pose encoding and walk-phase helper
package mario_sprite_pkg;

    localparam int SPR_W  = 21;
    localparam int SPR_H  = 21;
    localparam int SPR_AW = 9;

    // Palette index 0; the colour mapper treats it as see-through.
    localparam logic [11:0] TRANSPARENT_RGB = 12'h808;

    typedef enum logic [2:0] {
        STAND = 3'd0,
        WALK1 = 3'd1,
        WALK2 = 3'd2,
        WALK3 = 3'd3,
        JUMP  = 3'd4
    } pose_t;

    function automatic pose_t next_walk(input pose_t p);
        case (p)
            WALK1:   return WALK2;
            WALK2:   return WALK3;
            default: return WALK1;
        endcase
    endfunction

endpackage

// File: rtl/mario_sprite_addr_gen_if.sv
// rtl/mario_sprite_addr_gen_if.sv - scan/motion inputs and ROM-select outputs of the sprite address stage
interface mario_sprite_addr_gen_if;
    import mario_sprite_pkg::*;

    logic              vsync;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              moving;
    logic              airborne;
    logic              facing_left;
    logic [SPR_AW-1:0] read_address;
    logic              sprite_on;
    pose_t             pose;
    logic              dir_left;

    modport master (
        output vsync, DrawX, DrawY, pos_x, pos_y, moving, airborne, facing_left,
        input  read_address, sprite_on, pose, dir_left
    );

    modport slave (
        input  vsync, DrawX, DrawY, pos_x, pos_y, moving, airborne, facing_left,
        output read_address, sprite_on, pose, dir_left
    );

endinterface

// File: rtl/mario_anim_seq.sv
// rtl/mario_anim_seq.sv - vsync edge detect, walk divider, pose FSM and facing latch
module mario_anim_seq
    import mario_sprite_pkg::*;
#(
    parameter int ANIM_DIV = 6
) (
    input  logic  Clk,
    input  logic  Reset,
    input  logic  vsync_i,
    input  logic  moving_i,
    input  logic  airborne_i,
    input  logic  facing_left_i,
    output pose_t pose_o,
    output logic  dir_o
);

    localparam int            DW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    logic          vsync_q;
    logic          tick;
    pose_t         pose_q, pose_d;
    logic [DW-1:0] div_q, div_d;
    logic          dir_q, dir_d;

    assign tick = vsync_i & ~vsync_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vsync_q <= 1'b0;
            pose_q  <= STAND;
            div_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            pose_q  <= pose_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
        end
    end

    // Everything holds between ticks so a frame never mixes two poses.
    always_comb begin
        pose_d = pose_q;
        div_d  = div_q;
        dir_d  = dir_q;
        if (tick) begin
            dir_d = facing_left_i;
            if (airborne_i) begin
                pose_d = JUMP;
            end else if (!moving_i) begin
                pose_d = STAND;
                div_d  = '0;
            end else if (pose_q == STAND || pose_q == JUMP) begin
                pose_d = WALK1;
                div_d  = '0;
            end else if (div_q == DIV_LAST) begin
                pose_d = next_walk(pose_q);
                div_d  = '0;
            end else begin
                div_d  = div_q + 1'b1;
            end
        end
    end

    always_comb begin
        pose_o = pose_q;
        dir_o  = dir_q;
    end

endmodule

// File: rtl/mario_sprite_addr_gen.sv
// rtl/mario_sprite_addr_gen.sv - sprite hit test, ROM address and pose select (MARIO_SPRITE_MIRROR_EN: mirror in address)
module mario_sprite_addr_gen
    import mario_sprite_pkg::*;
#(
    parameter int ANIM_DIV = 6
) (
    input logic                   Clk,
    input logic                   Reset,
    mario_sprite_addr_gen_if.slave bus
);

    logic              dir_lat;
    pose_t             pose;
    logic [10:0]       x_end, y_end;
    logic              in_box;
    logic [4:0]        col, row, col_m;
    logic [SPR_AW-1:0] addr_d, addr_q;
    logic              on_d, on_q;

    mario_anim_seq #(.ANIM_DIV(ANIM_DIV)) u_anim (
        .Clk           (Clk),
        .Reset         (Reset),
        .vsync_i       (bus.vsync),
        .moving_i      (bus.moving),
        .airborne_i    (bus.airborne),
        .facing_left_i (bus.facing_left),
        .pose_o        (pose),
        .dir_o         (dir_lat)
    );

    // 11-bit box edges so a sprite near column 1023 does not wrap to column 0.
    assign x_end  = {1'b0, bus.pos_x} + 11'(SPR_W);
    assign y_end  = {1'b0, bus.pos_y} + 11'(SPR_H);
    assign in_box = (bus.DrawX >= bus.pos_x) && ({1'b0, bus.DrawX} < x_end) &&
                    (bus.DrawY >= bus.pos_y) && ({1'b0, bus.DrawY} < y_end);

    assign col = 5'(bus.DrawX - bus.pos_x);
    assign row = 5'(bus.DrawY - bus.pos_y);

`ifdef MARIO_SPRITE_MIRROR_EN
    assign col_m        = dir_lat ? (5'(SPR_W - 1) - col) : col;
    assign bus.dir_left = 1'b0;
`else
    assign col_m        = col;
    assign bus.dir_left = dir_lat;
`endif

    // row*21 as shift-add: 16+4+1.
    always_comb begin
        addr_d = '0;
        on_d   = in_box;
        if (in_box) begin
            addr_d = ({4'b0, row} << 4) + ({4'b0, row} << 2) + {4'b0, row} + {4'b0, col_m};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q <= '0;
            on_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            on_q   <= on_d;
        end
    end

    assign bus.read_address = addr_q;
    assign bus.sprite_on    = on_q;
    assign bus.pose         = pose;

endmodule

// File: tb/tb_mario_sprite_addr_gen.sv
// tb/tb_mario_sprite_addr_gen.sv - scoreboard bench for mario_sprite_addr_gen against a frame-count pose model
module tb_mario_sprite_addr_gen;

    localparam int ANIM_DIV = 6;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    mario_sprite_addr_gen_if b();

    mario_sprite_addr_gen #(.ANIM_DIV(ANIM_DIV)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b)
    );

    typedef struct {
        int due;
        int addr;
        int on;
        int pose;
        int dir;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Stimulus values and reference model state
    int px, py, dx, dy, vs, mv, air, fl;
    int m_prev_vs, m_dir, m_pose, m_walking, m_frames;

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_prev_vs = 0;
        m_dir     = 0;
        m_pose    = 0;
        m_walking = 0;
        m_frames  = 0;
    endtask

    // Drive one cycle of inputs, push what the outputs must be after the next edge.
    task automatic apply();
        exp_t e;
        int   in_box, col, row;
        b.vsync       = vs[0];
        b.DrawX       = 10'(dx);
        b.DrawY       = 10'(dy);
        b.pos_x       = 10'(px);
        b.pos_y       = 10'(py);
        b.moving      = mv[0];
        b.airborne    = air[0];
        b.facing_left = fl[0];

        in_box = (dx >= px && dx < px + 21 && dy >= py && dy < py + 21) ? 1 : 0;
        col = dx - px;
        row = dy - py;
`ifdef MARIO_SPRITE_MIRROR_EN
        if (m_dir != 0) col = 20 - col;
`endif
        e.addr = in_box ? row * 21 + col : 0;
        e.on   = in_box;

        if (vs != 0 && m_prev_vs == 0) begin
            if (air != 0) begin
                m_pose    = 4;
                m_walking = 0;
            end else if (mv == 0) begin
                m_pose    = 0;
                m_walking = 0;
            end else begin
                if (m_walking == 0) begin
                    m_walking = 1;
                    m_frames  = 0;
                end else begin
                    m_frames++;
                end
                m_pose = 1 + (m_frames / ANIM_DIV) % 3;
            end
            m_dir = fl;
        end
        m_prev_vs = vs;

        e.pose = m_pose;
`ifdef MARIO_SPRITE_MIRROR_EN
        e.dir  = 0;
`else
        e.dir  = m_dir;
`endif
        e.due  = cyc + 1;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic pixel(input int x, input int y);
        dx = x;
        dy = y;
        apply();
    endtask

    // One frame: vsync high two cycles, low for the rest.
    task automatic frame(input int len);
        vs = 1;
        apply();
        apply();
        vs = 0;
        for (int i = 2; i < len; i++) apply();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare whenever an expected response falls due.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            while (!Reset && sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL stale: due %0d checked at %0d", e.due, cyc);
                end else begin
                    check("read_address", int'(b.read_address), e.addr);
                    check("sprite_on", int'(b.sprite_on), e.on);
                    check("pose", int'(b.pose), e.pose);
                    check("dir_left", int'(b.dir_left), e.dir);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        px = 0; py = 0; dx = 0; dy = 0; vs = 0; mv = 0; air = 0; fl = 0;
        b.vsync = 1'b0; b.DrawX = '0; b.DrawY = '0; b.pos_x = '0; b.pos_y = '0;
        b.moving = 1'b0; b.airborne = 1'b0; b.facing_left = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("reset read_address", int'(b.read_address), 0);
        check("reset sprite_on", int'(b.sprite_on), 0);
        check("reset pose", int'(b.pose), 0);
        check("reset dir_left", int'(b.dir_left), 0);
        Reset = 1'b0;

        // Box corners and the first column past the box
        px = 100; py = 50;
        pixel(100, 50);
        pixel(120, 70);
        pixel(121, 70);
        pixel(99, 60);
        pixel(110, 71);
        // Right-edge sprite must not wrap back to column 5
        px = 1015; py = 200;
        pixel(1023, 200);
        pixel(5, 200);
        pixel(1016, 220);

        // Walk cycle through several phase advances, then stop
        px = 300; py = 300; dx = 305; dy = 310;
        mv = 1;
        for (int f = 0; f < 21; f++) frame(4);
        mv = 0;
        frame(4);
        // Jump overrides moving, then walking restarts at WALK1
        mv = 1; air = 1;
        frame(4);
        air = 0;
        frame(4);
        frame(4);
        // Facing changes mid-frame are held until the next vsync rise
        vs = 0;
        fl = 1;
        apply(); apply(); apply();
        frame(4);
        fl = 0;
        apply(); apply();
        fl = 1;
        frame(4);

        // Mirror probe with facing latched left
        px = 0; py = 0;
        pixel(0, 1);
        pixel(20, 0);

        // Mid-line asynchronous reset with nonzero outputs
        px = 0; py = 0; dx = 5; dy = 5;
        apply();
        drain();
        #2;
        Reset = 1'b1;
        #1;
        check("midreset read_address", int'(b.read_address), 0);
        check("midreset sprite_on", int'(b.sprite_on), 0);
        check("midreset pose", int'(b.pose), 0);
        check("midreset dir_left", int'(b.dir_left), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        mv = 0; air = 0; fl = 0; vs = 0;
        frame(4);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
            end
            dx = (px + $urandom_range(0, 30) - 5) & 1023;
            dy = (py + $urandom_range(0, 30) - 5) & 1023;
            if ($urandom_range(0, 3) == 0) vs = (vs == 0) ? 1 : 0;
            if ($urandom_range(0, 30) == 0) mv  = (mv == 0) ? 1 : 0;
            if ($urandom_range(0, 60) == 0) air = (air == 0) ? 1 : 0;
            if ($urandom_range(0, 20) == 0) fl  = (fl == 0) ? 1 : 0;
            apply();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
